// File: rtl/reg_display_select.sv
// rtl/reg_display_select.sv - Register selector/reader that feeds the 8-digit hex display.
// Define REG_DISPLAY_AUTOSCAN_EN to add periodic automatic index stepping.
module reg_display_select #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REFRESH_CYCLES  = 50000,
    parameter int unsigned AUTO_PERIOD     = 50000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_key_next_n,
    input  logic        i_key_prev_n,
    input  logic        i_freeze,
    output logic        o_rf_req,
    output logic [4:0]  o_rf_addr,
    input  logic        i_rf_ack,
    input  logic [31:0] i_rf_data,
    output logic [31:0] o_rs,
    output logic [4:0]  o_index,
    output logic        o_valid
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RF_W-1:0] RF_MAX = RF_W'(REFRESH_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    // Bit 0 carries the Next key, bit 1 the Prev key; keys idle high.
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      db_level_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [1:0]      press;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            db_level_q  <= 2'b11;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            sync1_q <= {i_key_prev_n, i_key_next_n};
            sync2_q <= sync1_q;
            for (int k = 0; k < 2; k++) begin
                if (sync2_q[k] == db_level_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == DB_MAX) begin
                    db_level_q[k] <= sync2_q[k];
                    db_cnt_q[k]   <= '0;
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // Press pulse is the cycle the debounced level is about to fall, so the
    // index can move on the same edge the press is accepted.
    assign press[0] = db_level_q[0] && !sync2_q[0] && (db_cnt_q[0] == DB_MAX);
    assign press[1] = db_level_q[1] && !sync2_q[1] && (db_cnt_q[1] == DB_MAX);

    logic manual_any;
    logic step_up;
    logic step_dn;
    logic step_any;

    assign manual_any = press[0] | press[1];
    assign step_dn    = press[1] & ~press[0];

`ifdef REG_DISPLAY_AUTOSCAN_EN
    localparam int AU_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AU_W-1:0] AU_MAX = AU_W'(AUTO_PERIOD - 1);

    logic [AU_W-1:0] auto_cnt_q;
    logic            auto_fire;

    assign auto_fire = (auto_cnt_q == AU_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            auto_cnt_q <= '0;
        end else if (manual_any || auto_fire) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_q + 1'b1;
        end
    end

    assign step_up = (press[0] & ~press[1]) | (auto_fire & ~manual_any);
`else
    assign step_up = press[0] & ~press[1];
`endif

    assign step_any = (step_up | step_dn) & ~i_freeze;

    state_t          state_q;
    logic [RF_W-1:0] ref_cnt_q;
    logic            pend_q;
    logic            pend_up_q;
    logic            dir_up_d;
    logic [4:0]      index_d;

    // A fresh event wins over a pending one; 5-bit arithmetic gives the wrap.
    always_comb begin
        dir_up_d = step_any ? step_up : pend_up_q;
        index_d  = dir_up_d ? (o_index + 5'd1) : (o_index - 5'd1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            ref_cnt_q <= '0;
            pend_q    <= 1'b0;
            pend_up_q <= 1'b0;
            o_rf_req  <= 1'b0;
            o_rf_addr <= 5'd0;
            o_rs      <= 32'd0;
            o_index   <= 5'd0;
            o_valid   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_freeze) begin
                        ref_cnt_q <= ref_cnt_q;
                    end else if (step_any || pend_q) begin
                        o_index   <= index_d;
                        o_rf_addr <= index_d;
                        o_valid   <= 1'b0;
                        o_rf_req  <= 1'b1;
                        pend_q    <= 1'b0;
                        ref_cnt_q <= '0;
                        state_q   <= S_REQ;
                    end else if (ref_cnt_q == RF_MAX) begin
                        o_rf_addr <= o_index;
                        o_rf_req  <= 1'b1;
                        ref_cnt_q <= '0;
                        state_q   <= S_REQ;
                    end else begin
                        ref_cnt_q <= ref_cnt_q + 1'b1;
                    end
                end
                S_REQ: begin
                    if (step_any) begin
                        pend_q    <= 1'b1;
                        pend_up_q <= step_up;
                    end
                    if (i_rf_ack) begin
                        o_rs     <= i_rf_data;
                        o_valid  <= 1'b1;
                        o_rf_req <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_display_select.sv
// tb/tb_reg_display_select.sv - Directed self-checking bench for reg_display_select.
module tb_reg_display_select;
`ifdef REG_DISPLAY_AUTOSCAN_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        key_next_n = 1'b1;
    logic        key_prev_n = 1'b1;
    logic        freeze     = 1'b0;
    logic        rf_ack     = 1'b0;
    logic        rf_req;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [31:0] rs;
    logic [4:0]  index;
    logic        valid;

    int errors  = 0;
    int checks  = 0;
    int ack_cnt = 0;

    always #5 clk = ~clk;

    reg_display_select #(
        .DEBOUNCE_CYCLES(4),
        .REFRESH_CYCLES (16),
        .AUTO_PERIOD    (64)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_key_next_n(key_next_n),
        .i_key_prev_n(key_prev_n),
        .i_freeze    (freeze),
        .o_rf_req    (rf_req),
        .o_rf_addr   (rf_addr),
        .i_rf_ack    (rf_ack),
        .i_rf_data   (rf_data),
        .o_rs        (rs),
        .o_index     (index),
        .o_valid     (valid)
    );

    // Register file model: ack two cycles after the request, data = 0xA000_0000 + addr.
    assign rf_data = 32'hA000_0000 + 32'(rf_addr);

    always @(negedge clk) begin
        if (!rst_n || !rf_req) begin
            ack_cnt = 0;
            rf_ack  = 1'b0;
        end else begin
            ack_cnt = ack_cnt + 1;
            rf_ack  = (ack_cnt == 2);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input logic level, input int budget, input string tag);
        int n = 0;
        while (rf_req !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (rf_req !== level) check(tag, 32'(rf_req), 32'(level));
    endtask

    task automatic press(input logic nxt, input logic prv);
        if (nxt) key_next_n = 1'b0;
        if (prv) key_prev_n = 1'b0;
        tick(10);
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        tick(12);
    endtask

    initial begin
        int n;
        int req_seen;

        // Reset values and the first refresh read
        tick(2);
        check("rst_rs", rs, 32'd0);
        check("rst_index", 32'(index), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_req", 32'(rf_req), 32'd0);
        check("rst_addr", 32'(rf_addr), 32'd0);
        rst_n = 1'b1;
        tick(15);
        check("first_req_early", 32'(rf_req), 32'd0);
        tick(1);
        check("first_req", 32'(rf_req), 32'd1);
        check("first_addr", 32'(rf_addr), 32'd0);
        tick(2);
        check("first_rs", rs, 32'hA000_0000);
        check("first_valid", 32'(valid), 32'd1);

`ifndef REG_DISPLAY_AUTOSCAN_EN
        // Wrap-around in both directions
        press(1'b0, 1'b1);
        check("prev_wrap_index", 32'(index), 32'd31);
        check("prev_wrap_rs", rs, 32'hA000_001F);
        press(1'b1, 1'b0);
        check("next_wrap_index", 32'(index), 32'd0);
        check("next_wrap_rs", rs, 32'hA000_0000);

        // Clean Next press: valid drops on the index edge and a read starts
        key_next_n = 1'b0;
        n = 0;
        while (index !== 5'd1 && n < 20) begin
            tick(1);
            n++;
        end
        check("next_index", 32'(index), 32'd1);
        check("next_valid_clr", 32'(valid), 32'd0);
        check("next_req", 32'(rf_req), 32'd1);
        check("next_addr", 32'(rf_addr), 32'd1);
        key_next_n = 1'b1;
        tick(12);
        check("next_rs", rs, 32'hA000_0001);
        check("next_valid", 32'(valid), 32'd1);

        // Bouncy press: short glitches must not count
        key_next_n = 1'b0; tick(2);
        key_next_n = 1'b1; tick(2);
        key_next_n = 1'b0; tick(2);
        key_next_n = 1'b1; tick(2);
        press(1'b1, 1'b0);
        check("bounce_index", 32'(index), 32'd2);
        check("bounce_rs", rs, 32'hA000_0002);

        // Both keys accepted together cancel out
        press(1'b1, 1'b1);
        check("both_index", 32'(index), 32'd2);

        // Press accepted during REQ becomes a pending step
        wait_req(1'b1, 40, "pend_wait_req");
        wait_req(1'b0, 10, "pend_wait_ack");
        tick(11);
        key_next_n = 1'b0;
        tick(6);
        check("pend_hold_index", 32'(index), 32'd2);
        check("pend_hold_req", 32'(rf_req), 32'd1);
        tick(1);
        check("pend_ack_req", 32'(rf_req), 32'd0);
        check("pend_ack_index", 32'(index), 32'd2);
        tick(1);
        check("pend_apply_index", 32'(index), 32'd3);
        check("pend_apply_req", 32'(rf_req), 32'd1);
        check("pend_apply_addr", 32'(rf_addr), 32'd3);
        check("pend_apply_valid", 32'(valid), 32'd0);
        key_next_n = 1'b1;
        tick(12);
        check("pend_rs", rs, 32'hA000_0003);

        // Freeze raised mid-REQ lets the transaction finish, then blocks everything
        wait_req(1'b1, 40, "frz_wait_req");
        freeze = 1'b1;
        wait_req(1'b0, 10, "frz_wait_ack");
        check("frz_valid", 32'(valid), 32'd1);
        check("frz_rs", rs, 32'hA000_0003);
        req_seen = 0;
        for (int i = 0; i < 100; i++) begin
            key_next_n = (i >= 5 && i < 15) ? 1'b0 : 1'b1;
            tick(1);
            if (rf_req) req_seen++;
        end
        check("frz_no_req", 32'(req_seen), 32'd0);
        check("frz_index", 32'(index), 32'd3);
        check("frz_rs_hold", rs, 32'hA000_0003);
        freeze = 1'b0;
`endif

        // Autoscan stepping (or its absence) from a fresh reset
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(63);
        check("auto_pre64", 32'(index), 32'd0);
        tick(1);
        check("auto_64", 32'(index), AUTO ? 32'd1 : 32'd0);
        tick(63);
        check("auto_pre128", 32'(index), AUTO ? 32'd1 : 32'd0);
        tick(1);
        check("auto_128", 32'(index), AUTO ? 32'd2 : 32'd0);

        // Reset mid-REQ drops the request without waiting for a clock
        wait_req(1'b1, 40, "rstreq_wait");
        rst_n = 1'b0;
        #1;
        check("rstreq_req", 32'(rf_req), 32'd0);
        check("rstreq_addr", 32'(rf_addr), 32'd0);
        check("rstreq_index", 32'(index), 32'd0);
        check("rstreq_valid", 32'(valid), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("rstreq_late_req", 32'(rf_req), 32'd0);
        check("rstreq_late_rs", rs, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
